// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: serves each load/store with a fixed LATENCY-cycle stall.
// Optional misaligned-access trap is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] DmmRD,
  output logic        StallM,
  output logic        AddrErrM
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic [1:0]    low_q;
  logic [31:0]   data_q;
  logic          wr_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          req;
  logic          enter_done;
  logic [AW-1:0] idx_s;
  logic [1:0]    low_s;
  logic [31:0]   data_s;
  logic          wr_s;
  logic          mis_s;

  assign req    = MemWriteM | MemtoRegM;
  assign StallM = reset && ((state == IDLE && req) || state == BUSY);

  // With LATENCY=1 DONE is entered straight from IDLE, so the live request is used
  // instead of the copy being latched on that same edge.
  always_comb begin
    if (state == IDLE) begin
      idx_s  = ALUOutM[AW+1:2];
      low_s  = ALUOutM[1:0];
      data_s = WriteDataM;
      wr_s   = MemWriteM;
    end else begin
      idx_s  = idx_q;
      low_s  = low_q;
      data_s = data_q;
      wr_s   = wr_q;
    end
    enter_done = reset && ((state == IDLE && req && LATENCY == 1) ||
                           (state == BUSY && cnt == 4'd1));
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_s = (low_s != 2'b00);
`else
  assign mis_s = 1'b0;
`endif

  // Memory array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (enter_done && wr_s && !mis_s)
      mem[idx_s] <= data_s;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      DmmRD  <= '0;
      idx_q  <= '0;
      low_q  <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
    end else begin
      if (enter_done)
        DmmRD <= mis_s ? '0 : mem[idx_s];
      case (state)
        IDLE: begin
          if (req) begin
            idx_q  <= ALUOutM[AW+1:2];
            low_q  <= ALUOutM[1:0];
            data_q <= WriteDataM;
            wr_q   <= MemWriteM;
            cnt    <= 4'(LATENCY - 1);
            state  <= (LATENCY == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      AddrErrM <= 1'b0;
    else if (enter_done)
      AddrErrM <= mis_s;
    else if (state == DONE)
      AddrErrM <= 1'b0;
  end
`else
  assign AddrErrM = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, ALUOutM[31:AW+2], low_s};

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=1 instances, directed table plus random traffic
// checked against an array-based memory model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mw [2];
  logic        mr [2];
  logic [31:0] addr [2];
  logic [31:0] wd [2];
  logic [31:0] rd [2];
  logic        stall [2];
  logic        aerr [2];

  int checks = 0;
  int errors = 0;
  int lat [2] = '{2, 1};

  logic [31:0] mm [2][256];
  bit          known [2][256];
  logic [31:0] prev [2];

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(2), .DEPTH_WORDS(256)) dut0 (
    .clk(clk), .reset(reset), .MemWriteM(mw[0]), .MemtoRegM(mr[0]),
    .ALUOutM(addr[0]), .WriteDataM(wd[0]), .DmmRD(rd[0]), .StallM(stall[0]),
    .AddrErrM(aerr[0]));

  dmem_responder #(.LATENCY(1), .DEPTH_WORDS(256)) dut1 (
    .clk(clk), .reset(reset), .MemWriteM(mw[1]), .MemtoRegM(mr[1]),
    .ALUOutM(addr[1]), .WriteDataM(wd[1]), .DmmRD(rd[1]), .StallM(stall[1]),
    .AddrErrM(aerr[1]));

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] xrd;
    logic        xerr;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: word-addressed array, aliasing by modulo, write returns old contents.
  task automatic model(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] xrd, output logic xerr, output bit k);
    int  idx;
    bit  mis;
    idx = int'((a >> 2) % 256);
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (a % 4) != 0;
`else
    mis = 1'b0;
`endif
    k    = mis || known[s][idx];
    xrd  = mis ? 32'h0 : mm[s][idx];
    xerr = mis;
    if (w && !mis) begin
      mm[s][idx]    = d;
      known[s][idx] = 1'b1;
    end
  endtask

  // Called at posedge+1; request is raised for cycle 0 and dropped after the DONE cycle.
  task automatic access(input int s, input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input bit crd, input logic [31:0] xrd,
                        input logic xerr);
    mw[s] = w; mr[s] = r; addr[s] = a; wd[s] = d;
    for (int c = 0; c < lat[s]; c++) begin
      @(negedge clk);
      chk("stall_busy", 32'(stall[s]), 32'd1);
      chk("rd_hold", rd[s], prev[s]);
      chk("err_low", 32'(aerr[s]), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("stall_done", 32'(stall[s]), 32'd0);
    if (crd) chk("rd_done", rd[s], xrd);
    chk("err_done", 32'(aerr[s]), 32'(xerr));
    prev[s] = crd ? xrd : rd[s];
    mw[s] = 1'b0; mr[s] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic acc_m(input int s, input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d);
    logic [31:0] xrd;
    logic        xerr;
    bit          k;
    model(s, w, a, d, xrd, xerr, k);
    access(s, w, r, a, d, k, xrd, xerr);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        chk("stall_idle", 32'(stall[s]), 32'd0);
        chk("rd_idle_hold", rd[s], prev[s]);
        chk("err_idle", 32'(aerr[s]), 32'd0);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] xr;
    logic        xe;
    bit          k;
    logic        w;
    logic        r;
    logic [31:0] a;

    for (int s = 0; s < 2; s++) begin
      mw[s] = 1'b0; mr[s] = 1'b0; addr[s] = '0; wd[s] = '0; prev[s] = '0;
      for (int i = 0; i < 256; i++) known[s][i] = 1'b0;
    end

    // Reset with a request pending: StallM must stay low.
    mw[0] = 1'b1; mr[1] = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_stall", 32'(stall[s]), 32'd0);
      chk("rst_rd", rd[s], 32'h0);
      chk("rst_err", 32'(aerr[s]), 32'd0);
    end
    mw[0] = 1'b0; mr[1] = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    idle(1);

    for (int i = 0; i < 256; i++)
      acc_m(0, 1'b1, 1'b0, 32'(i * 4), 32'h1000_0000 + 32'(i));

    tbl[0]  = '{1'b1, 1'b0, 32'h10,  32'hDEADBEEF, 32'h1000_0004, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'h10,  32'h0,        32'hDEADBEEF,  1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h400, 32'hCAFEF00D, 32'h1000_0000, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 32'h000, 32'h0,        32'hCAFEF00D,  1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h8,   32'h9,        32'h1000_0002, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 32'h8,   32'h5,        32'h9,         1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h8,   32'h0,        32'h5,         1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h20,  32'h1,        32'h1000_0008, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
    tbl[8]  = '{1'b1, 1'b0, 32'h22,  32'hFFFFFFFF, 32'h0,         1'b1};
    tbl[9]  = '{1'b0, 1'b1, 32'h20,  32'h0,        32'h1,         1'b0};
`else
    tbl[8]  = '{1'b1, 1'b0, 32'h22,  32'hFFFFFFFF, 32'h1,         1'b0};
    tbl[9]  = '{1'b0, 1'b1, 32'h20,  32'h0,        32'hFFFFFFFF,  1'b0};
`endif
    tbl[10] = '{1'b0, 1'b1, 32'h3FC, 32'h0,        32'h1000_00FF, 1'b0};

    for (int i = 0; i < 11; i++) begin
      model(0, tbl[i].w, tbl[i].a, tbl[i].d, xr, xe, k);
      access(0, tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, 1'b1, tbl[i].xrd, tbl[i].xerr);
    end
    idle(1);

    // Reset while BUSY abandons the store.
    acc_m(0, 1'b1, 1'b0, 32'h20, 32'hAAAAAAAA);
    mw[0] = 1'b1; addr[0] = 32'h20; wd[0] = 32'h12345678;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall[0]), 32'd0);
    chk("midrst_rd", rd[0], 32'h0);
    chk("midrst_err", 32'(aerr[0]), 32'd0);
    mw[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    prev[0] = '0; prev[1] = '0;
    @(posedge clk); #1;
    access(0, 1'b0, 1'b1, 32'h20, 32'h0, 1'b1, 32'hAAAAAAAA, 1'b0);

    // LATENCY=1 back-to-back loads: StallM 1,0,1,0.
    acc_m(1, 1'b1, 1'b0, 32'h0, 32'h11111111);
    acc_m(1, 1'b1, 1'b0, 32'h4, 32'h22222222);
    model(1, 1'b0, 32'h0, 32'h0, xr, xe, k);
    access(1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 32'h11111111, 1'b0);
    model(1, 1'b0, 32'h4, 32'h0, xr, xe, k);
    access(1, 1'b0, 1'b1, 32'h4, 32'h0, 1'b1, 32'h22222222, 1'b0);

    for (int n = 0; n < 240; n++) begin
      int s;
      s = (n % 3 == 0) ? 1 : 0;
      w = 1'($urandom_range(0, 1));
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if (s == 1) a = a & 32'hFFFF_FC07;
      acc_m(s, w, r, a, $urandom);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
    end
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the five-stage pipeline: the target side of the Memory-stage load/store interface. It accepts the M-stage request (ALUOutM address, WriteDataM, MemWriteM, MemtoRegM) and serves it with a fixed multi-cycle latency. While the access is outstanding it asserts StallM to the hazard unit, then presents DmmRD for exactly one cycle so the M/W register captures it.

## Interface
- LATENCY, 2: stall cycles per access; legal values are 1..15.
- DEPTH_WORDS, 256: number of 32-bit words; must be a power of two.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- MemWriteM  in  1  store request.
- MemtoRegM  in  1  load request.
- ALUOutM  in  32  byte address.
- WriteDataM  in  32  store data.
- DmmRD  out  32  load data; registered; valid in DONE.
- StallM  out  1  hold F/D/E/M; the hazard unit ORs it into StallF and StallD and freezes D/E and E/M.
- AddrErrM  out  1  misaligned-access flag; valid in DONE.

## Operation
- Request: req = MemWriteM | MemtoRegM. Op is a write if MemWriteM = 1, otherwise a read. When both flags are set, the write wins.
- Word index: ALUOutM[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses alias modulo DEPTH_WORDS*4.
- States:
  - IDLE:
    - req = 1: latch address, write data and op; load cnt = LATENCY-1. Next state is DONE if LATENCY = 1, otherwise BUSY.
    - req = 0: stay in IDLE.
  - BUSY: cnt decrements each cycle; when cnt = 1 the next state is DONE.
  - DONE: lasts exactly one cycle, then IDLE unconditionally.
- Memory action on the transition into DONE, using the latched index:
  - Read: DmmRD <= mem[idx].
  - Write: DmmRD <= mem[idx] (old value) and mem[idx] <= latched data. The write is performed exactly once.
- StallM = (IDLE & req) | BUSY. StallM is combinational and is 0 in DONE, so the pipeline advances on the edge that leaves DONE.
- A request present in IDLE right after DONE belongs to the next instruction and starts a new access. Back-to-back accesses therefore take LATENCY+1 cycles each.
- DmmRD holds its value in IDLE and BUSY.
- Reset (asynchronous, reset = 0):
  - Outputs and state: state = IDLE, cnt = 0, DmmRD = 0, AddrErrM = 0.
  - An in-flight access is abandoned and no write is performed.
  - Memory array contents are not cleared.
  - StallM is 0 during reset. After release it follows IDLE & req.

## Timing
- Request seen in cycle 0. StallM is high in cycles 0..LATENCY-1. DONE occurs in cycle LATENCY, with DmmRD valid during it.
- Load-to-use: the M/W register samples DmmRD at the end of cycle LATENCY.
- Inputs must be held stable while StallM = 1; they are latched at accept regardless.
- AddrErrM is registered. It changes only on DONE entry, is high only in DONE, and is cleared on DONE exit.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - An access is misaligned when ALUOutM[1:0] != 0 at accept.
  - A misaligned write leaves memory unchanged.
  - A misaligned read returns DmmRD = 0.
  - AddrErrM = 1 during DONE.
  - Latency is unchanged.
- DMEM_MISALIGN_TRAP_EN undefined:
  - ALUOutM[1:0] is ignored and the access proceeds on the word index.
  - AddrErrM is tied to 0.

## Test plan
- LATENCY=2, store 0xDEADBEEF to 0x10, then load 0x10:
  - Store: StallM = 1,1,0, DONE in cycle 2.
  - Load: StallM = 1,1,0 from cycle 3; DmmRD = 0xDEADBEEF in cycle 5.
- LATENCY=1, back-to-back loads of 0x0 and 0x4 preloaded with 0x11111111 and 0x22222222: StallM = 1,0,1,0; DmmRD = 0x11111111 then 0x22222222 in the DONE cycles.
- DEPTH_WORDS=256, store 0xCAFEF00D to 0x400, then load 0x000 -> 0xCAFEF00D (alias).
- Store 0x12345678 to 0x20 holding 0xAAAAAAAA; assert reset in BUSY -> StallM 0, DmmRD 0. A subsequent load of 0x20 returns 0xAAAAAAAA.
- MemWriteM = MemtoRegM = 1, data 0x5, address 0x8 holding 0x9 -> DmmRD = 0x9 in DONE; a later load of 0x8 returns 0x5.
- DMEM_MISALIGN_TRAP_EN defined, store 0xFFFFFFFF to 0x22 (word 0x20 holds 0x1) -> AddrErrM = 1 in DONE; a later load of 0x20 returns 0x1. Macro undefined -> AddrErrM = 0 and word 0x20 becomes 0xFFFFFFFF.
